// File: rtl/osd_bank_scheduler_pkg.sv
// osd_pkg: shared definitions for the OSD character RAM ping-pong scheduler.
// Contents: scheduler state encoding and default widths / frame timeout.
package osd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PEND = 2'd2
  } osd_state_e;

  localparam int OSD_ADDR_W         = 11;
  localparam int OSD_CNT_W          = 8;
  localparam int OSD_TIMEOUT_FRAMES = 60;

endpackage

// File: rtl/osd_bank_scheduler_if.sv
// osd_bank_scheduler_if: writer handshake, vsync, read-address and status
// signals between the UDP receive path, osd_display and the bank scheduler.
//   master : drives i_vs, wr_req, wr_done, wr_abort, rd_addr_in
//   slave  : the scheduler; drives wr_gnt, wr_bank, rd_addr_out,
//            udp_rec_data_valid, swap_pulse, wait_frames
interface osd_bank_scheduler_if
  import osd_pkg::*;
#(
  parameter int ADDR_W = OSD_ADDR_W,
  parameter int CNT_W  = OSD_CNT_W
);
  logic              i_vs;
  logic              wr_req;
  logic              wr_done;
  logic              wr_abort;
  logic              wr_gnt;
  logic              wr_bank;
  logic [ADDR_W-1:0] rd_addr_in;
  logic [ADDR_W:0]   rd_addr_out;
  logic              udp_rec_data_valid;
  logic              swap_pulse;
  logic [CNT_W-1:0]  wait_frames;

  modport master (
    output i_vs, wr_req, wr_done, wr_abort, rd_addr_in,
    input  wr_gnt, wr_bank, rd_addr_out, udp_rec_data_valid, swap_pulse,
           wait_frames
  );

  modport slave (
    input  i_vs, wr_req, wr_done, wr_abort, rd_addr_in,
    output wr_gnt, wr_bank, rd_addr_out, udp_rec_data_valid, swap_pulse,
           wait_frames
  );
endinterface

// File: rtl/osd_frame_timer.sv
// osd_frame_timer: counts vsync rises since the last bank swap and flags when
// TIMEOUT_FRAMES have elapsed. Saturates at the terminal value (no wrap).
// Ports:
//   video_clk, rst_n : pixel clock, async active-low reset
//   i_tick           : vsync rise
//   i_clr            : bank swap; clears the count (wins over i_tick)
//   o_hit            : count has reached TIMEOUT_FRAMES
module osd_frame_timer
  import osd_pkg::*;
#(
  parameter int TIMEOUT_FRAMES = OSD_TIMEOUT_FRAMES
) (
  input  logic video_clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_clr,
  output logic o_hit
);
  localparam int             CW   = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CW-1:0]  TERM = CW'(TIMEOUT_FRAMES);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick && (r_cnt != TERM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = (r_cnt == TERM);
endmodule

// File: rtl/osd_bank_scheduler.sv
// osd_bank_scheduler: ping-pong controller for the OSD character RAM. Grants
// the UDP writer the back bank, holds a filled bank until the next vsync rise,
// then swaps so osd_display always reads a complete frame.
// Ports:
//   video_clk, rst_n : pixel clock, async active-low reset
//   bus (slave)      : vsync, writer handshake, read address, status outputs
// Build option: OSD_TIMEOUT_EN adds osd_frame_timer, which blanks the valid
// flag after TIMEOUT_FRAMES vsyncs without a swap.
//
// state | meaning
// IDLE  | no bank owned by the writer
// FILL  | writer owns the back bank
// PEND  | back bank full, waiting for a vsync rise to swap
module osd_bank_scheduler
  import osd_pkg::*;
#(
  parameter int ADDR_W         = OSD_ADDR_W,
  parameter int CNT_W          = OSD_CNT_W,
  parameter int TIMEOUT_FRAMES = OSD_TIMEOUT_FRAMES
) (
  input  logic                 video_clk,
  input  logic                 rst_n,
  osd_bank_scheduler_if.slave  bus
);
  osd_state_e       r_state;
  osd_state_e       w_next_state;
  logic             r_vs_d;
  logic             r_front_bank;
  logic             r_valid;
  logic             r_swap;
  logic [CNT_W-1:0] r_wait;
  logic             w_vs_rise;
  logic             w_swap;
  logic             w_timeout_hit;

  assign w_vs_rise = bus.i_vs & ~r_vs_d;
  // A bank completed on this very edge is still in FILL, so it cannot swap
  // until the following vsync rise.
  assign w_swap    = (r_state == ST_PEND) & w_vs_rise;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (bus.wr_req) w_next_state = ST_FILL;
      ST_FILL: begin
        if (bus.wr_done)       w_next_state = ST_PEND;
        else if (bus.wr_abort) w_next_state = ST_IDLE;
      end
      ST_PEND: if (w_vs_rise) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d       <= 1'b0;
      r_front_bank <= 1'b0;
      r_valid      <= 1'b0;
      r_swap       <= 1'b0;
      r_wait       <= '0;
    end else begin
      r_vs_d <= bus.i_vs;
      r_swap <= w_swap;
      if (w_swap) r_front_bank <= ~r_front_bank;
      if (w_swap)             r_valid <= 1'b1;
      else if (w_timeout_hit) r_valid <= 1'b0;
      if (w_swap && bus.wr_req && (r_wait != {CNT_W{1'b1}})) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

`ifdef OSD_TIMEOUT_EN
  osd_frame_timer #(
    .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
  ) u_frame_timer (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .i_tick    (w_vs_rise),
    .i_clr     (w_swap),
    .o_hit     (w_timeout_hit)
  );
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_FRAMES > 0);
  assign w_timeout_hit        = 1'b0;
`endif

  assign bus.wr_gnt             = (r_state == ST_FILL);
  assign bus.wr_bank            = ~r_front_bank;
  assign bus.rd_addr_out        = {r_front_bank, bus.rd_addr_in};
  assign bus.udp_rec_data_valid = r_valid;
  assign bus.swap_pulse         = r_swap;
  assign bus.wait_frames        = r_wait;
endmodule

// File: tb/tb_osd_bank_scheduler.sv
// Bench for osd_bank_scheduler: directed scenarios plus a randomized run
// compared against a rule-level model of the ping-pong behaviour.
module tb_osd_bank_scheduler;
  localparam int AW = 11;
  localparam int CW = 8;
  localparam int TF = 4;

  logic video_clk = 1'b0;
  logic rst_n     = 1'b0;
  always #5 video_clk = ~video_clk;

  osd_bank_scheduler_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  osd_bank_scheduler #(.ADDR_W(AW), .CNT_W(CW), .TIMEOUT_FRAMES(TF)) dut (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .bus       (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: writer ownership, a full bank waiting for display, which bank is
  // shown, whether it is valid, and frames since the last swap.
  bit m_vs_prev, m_owned, m_full, m_front, m_valid, m_swap;
  int m_waits, m_frames;

  task automatic model_reset();
    m_vs_prev = 0; m_owned = 0; m_full = 0; m_front = 0;
    m_valid = 0; m_swap = 0; m_waits = 0; m_frames = 0;
  endtask

  // Apply current inputs across one rising edge, updating the model.
  task automatic tick();
    bit rise;
    rise   = bus.i_vs && !m_vs_prev;
    m_swap = m_full && rise;
    if (m_swap) begin
      m_front  = !m_front;
      m_full   = 0;
      m_valid  = 1;
      m_frames = 0;
      if (bus.wr_req && m_waits < 255) m_waits++;
    end else begin
`ifdef OSD_TIMEOUT_EN
      if (m_frames == TF) m_valid = 0;
      if (rise && m_frames < TF) m_frames++;
`endif
      if (m_owned) begin
        if (bus.wr_done) begin m_owned = 0; m_full = 1; end
        else if (bus.wr_abort) m_owned = 0;
      end else if (!m_full && bus.wr_req) begin
        m_owned = 1;
      end
    end
    m_vs_prev = bus.i_vs;
    @(posedge video_clk);
    #1;
  endtask

  task automatic set_in(input bit vs, input bit req, input bit done, input bit abort);
    bus.i_vs = vs; bus.wr_req = req; bus.wr_done = done; bus.wr_abort = abort;
  endtask

  task automatic reset_dut();
    rst_n = 0;
    set_in(0, 0, 0, 0);
    bus.rd_addr_in = 11'h005;
    model_reset();
    repeat (2) @(posedge video_clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (bus.wr_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", bus.wr_gnt); end
    checks++; if (bus.wr_bank !== 1'b1) begin errors++; $display("FAIL reset_wr_bank got %b want 1", bus.wr_bank); end
    checks++; if (bus.udp_rec_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.udp_rec_data_valid); end
    checks++; if (bus.swap_pulse !== 1'b0) begin errors++; $display("FAIL reset_swap got %b want 0", bus.swap_pulse); end
    checks++; if (bus.wait_frames !== 8'h00) begin errors++; $display("FAIL reset_wait got %h want 00", bus.wait_frames); end
    checks++; if (bus.rd_addr_out !== 12'h005) begin errors++; $display("FAIL reset_rd_addr got %h want 005", bus.rd_addr_out); end
  endtask

  task automatic test_basic();
    reset_dut();
    set_in(0, 1, 0, 0); tick();
    checks++; if (bus.wr_gnt !== 1'b1) begin errors++; $display("FAIL basic_gnt got %b want 1", bus.wr_gnt); end
    checks++; if (bus.wr_bank !== 1'b1) begin errors++; $display("FAIL basic_wr_bank got %b want 1", bus.wr_bank); end
    set_in(0, 0, 1, 0); tick();
    checks++; if (bus.wr_gnt !== 1'b0) begin errors++; $display("FAIL basic_gnt_drop got %b want 0", bus.wr_gnt); end
    set_in(1, 0, 0, 0); tick();
    checks++; if (bus.swap_pulse !== 1'b1) begin errors++; $display("FAIL basic_swap got %b want 1", bus.swap_pulse); end
    checks++; if (bus.rd_addr_out !== 12'h805) begin errors++; $display("FAIL basic_rd_addr got %h want 805", bus.rd_addr_out); end
    checks++; if (bus.udp_rec_data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", bus.udp_rec_data_valid); end
    checks++; if (bus.wr_bank !== 1'b0) begin errors++; $display("FAIL basic_wr_bank_after got %b want 0", bus.wr_bank); end
    tick();
    checks++; if (bus.swap_pulse !== 1'b0) begin errors++; $display("FAIL basic_swap_end got %b want 0", bus.swap_pulse); end
    set_in(0, 0, 0, 0); tick();
  endtask

  task automatic test_done_with_vs();
    // front bank is 1 coming in from test_basic
    set_in(0, 1, 0, 0); tick();
    set_in(1, 0, 1, 0); tick();
    checks++; if (bus.swap_pulse !== 1'b0) begin errors++; $display("FAIL dvs_no_swap got %b want 0", bus.swap_pulse); end
    set_in(1, 0, 0, 0); tick(); tick();
    set_in(0, 0, 0, 0); tick(); tick();
    checks++; if (bus.rd_addr_out[AW] !== 1'b1) begin errors++; $display("FAIL dvs_front_held got %b want 1", bus.rd_addr_out[AW]); end
    set_in(1, 0, 0, 0); tick();
    checks++; if (bus.swap_pulse !== 1'b1) begin errors++; $display("FAIL dvs_next_swap got %b want 1", bus.swap_pulse); end
    checks++; if (bus.rd_addr_out[AW] !== 1'b0) begin errors++; $display("FAIL dvs_front_new got %b want 0", bus.rd_addr_out[AW]); end
    set_in(0, 0, 0, 0); tick();
  endtask

  task automatic test_abort();
    set_in(0, 1, 0, 0); tick();
    checks++; if (bus.wr_gnt !== 1'b1) begin errors++; $display("FAIL abort_gnt got %b want 1", bus.wr_gnt); end
    set_in(0, 0, 0, 1); tick();
    checks++; if (bus.wr_gnt !== 1'b0) begin errors++; $display("FAIL abort_gnt_drop got %b want 0", bus.wr_gnt); end
    set_in(1, 0, 0, 0); tick();
    checks++; if (bus.swap_pulse !== 1'b0) begin errors++; $display("FAIL abort_no_swap got %b want 0", bus.swap_pulse); end
    checks++; if (bus.rd_addr_out[AW] !== 1'b0) begin errors++; $display("FAIL abort_front got %b want 0", bus.rd_addr_out[AW]); end
    set_in(0, 0, 0, 0); tick();
  endtask

  task automatic test_wait_frames();
    reset_dut();
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 1, 0); tick();
    // PEND with the writer asking again: swap on the first of three vsyncs
    for (int v = 0; v < 3; v++) begin
      set_in(1, 1, 0, 0); tick();
      set_in(0, 1, 0, 0); tick();
    end
    checks++; if (bus.wait_frames !== 8'd1) begin errors++; $display("FAIL wait_one got %0d want 1", bus.wait_frames); end
    set_in(0, 1, 1, 0); tick();
    for (int i = 1; i <= 300; i++) begin
      set_in(1, 1, 0, 0); tick();
      set_in(0, 1, 0, 0); tick();
      set_in(0, 1, 1, 0); tick();
      if (i == 253) begin
        checks++; if (bus.wait_frames !== 8'hFE) begin errors++; $display("FAIL wait_fe got %h want fe", bus.wait_frames); end
      end
    end
    checks++; if (bus.wait_frames !== 8'hFF) begin errors++; $display("FAIL wait_sat got %h want ff", bus.wait_frames); end
    checks++; if (bus.wait_frames !== 8'(m_waits)) begin errors++; $display("FAIL wait_model got %h want %h", bus.wait_frames, 8'(m_waits)); end
    set_in(0, 0, 0, 0); tick();
  endtask

  task automatic test_timeout();
    bit exp_after;
`ifdef OSD_TIMEOUT_EN
    exp_after = 0;
`else
    exp_after = 1;
`endif
    reset_dut();
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 1, 0); tick();
    set_in(1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0); tick();
    checks++; if (bus.udp_rec_data_valid !== 1'b1) begin errors++; $display("FAIL to_valid_first got %b want 1", bus.udp_rec_data_valid); end
    for (int v = 0; v < 4; v++) begin
      set_in(1, 0, 0, 0); tick();
      set_in(0, 0, 0, 0); tick();
      if (v == 3) begin
        checks++; if (bus.udp_rec_data_valid !== exp_after) begin errors++; $display("FAIL to_valid_after4 got %b want %b", bus.udp_rec_data_valid, exp_after); end
      end else begin
        checks++; if (bus.udp_rec_data_valid !== 1'b1) begin errors++; $display("FAIL to_valid_early got %b want 1", bus.udp_rec_data_valid); end
      end
    end
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 1, 0); tick();
    set_in(1, 0, 0, 0); tick();
    checks++; if (bus.udp_rec_data_valid !== 1'b1) begin errors++; $display("FAIL to_valid_reswap got %b want 1", bus.udp_rec_data_valid); end
    set_in(0, 0, 0, 0); tick();
  endtask

  task automatic test_async_reset();
    reset_dut();
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 1, 0); tick();
    set_in(1, 0, 0, 0); tick();
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 1, 0); tick();
    // now PEND, front 1, valid 1; drop reset between edges
    #2;
    rst_n = 0;
    #1;
    checks++; if (bus.rd_addr_out[AW] !== 1'b0 || bus.wr_bank !== 1'b1) begin errors++; $display("FAIL areset_front got %b want 0", bus.rd_addr_out[AW]); end
    checks++; if (bus.udp_rec_data_valid !== 1'b0 || bus.wr_gnt !== 1'b0 || bus.swap_pulse !== 1'b0) begin errors++; $display("FAIL areset_flags got v%b g%b s%b want 000", bus.udp_rec_data_valid, bus.wr_gnt, bus.swap_pulse); end
    #1;
    rst_n = 1;
    model_reset();
    set_in(1, 0, 0, 0); tick();
    checks++; if (bus.swap_pulse !== 1'b0) begin errors++; $display("FAIL areset_no_swap got %b want 0", bus.swap_pulse); end
    checks++; if (bus.rd_addr_out[AW] !== 1'b0) begin errors++; $display("FAIL areset_front_kept got %b want 0", bus.rd_addr_out[AW]); end
    set_in(0, 0, 0, 0); tick();
  endtask

  task automatic test_random();
    bit vs;
    logic [AW:0] exp_addr;
    reset_dut();
    vs = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(7) == 0) vs = !vs;
      set_in(vs, $urandom_range(1) == 1, $urandom_range(3) == 0, $urandom_range(3) == 0);
      bus.rd_addr_in = AW'($urandom);
      tick();
      exp_addr = {m_front, bus.rd_addr_in};
      checks++;
      if (bus.wr_gnt !== m_owned || bus.wr_bank !== !m_front || bus.swap_pulse !== m_swap ||
          bus.udp_rec_data_valid !== m_valid || bus.wait_frames !== 8'(m_waits) ||
          bus.rd_addr_out !== exp_addr) begin
        errors++;
        $display("FAIL rand_c%0d got g%b b%b s%b v%b w%h a%h want g%b b%b s%b v%b w%h a%h", c,
                 bus.wr_gnt, bus.wr_bank, bus.swap_pulse, bus.udp_rec_data_valid, bus.wait_frames, bus.rd_addr_out,
                 m_owned, !m_front, m_swap, m_valid, 8'(m_waits), exp_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_done_with_vs();
    test_abort();
    test_wait_frames();
    test_timeout();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
